// File: rtl/car_direction_fsm.sv
// Car direction detector: two synchronized, debounced optical sensors feed a
// sequence FSM that pulses car_in/car_out. Optional stall watchdog: CAR_FSM_TIMEOUT_EN.
module car_direction_fsm #(
  parameter int DB_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sens_a,
  input  logic       sens_b,
  output logic       car_in,
  output logic       car_out,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IN1      = 3'd1,
    IN2      = 3'd2,
    IN3      = 3'd3,
    OUT1     = 3'd4,
    OUT2     = 3'd5,
    OUT3     = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db
    $error("DB_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range");
  end

  // Bit 1 carries sensor a, bit 0 sensor b throughout.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;

  state_t state_q, state_d;
  logic   car_in_q, car_in_d;
  logic   car_out_q, car_out_d;
  logic   err_q, err_d;
  logic   cnt_en_q, cnt_en_d;
  logic   cnt_up_q, cnt_up_d;

`ifdef CAR_FSM_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    sync1_d = {sens_a, sens_b};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = 8'd0;
      // Counter only runs while the synchronized level disagrees; any reversion zeroes it.
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    car_in_d  = 1'b0;
    car_out_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: case (filt_q)
        2'b10:   state_d = IN1;
        2'b01:   state_d = OUT1;
        2'b11:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = IDLE;
      endcase
      IN1: case (filt_q)
        2'b11:   state_d = IN2;
        2'b00:   state_d = IDLE;
        2'b01:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = IN1;
      endcase
      IN2: case (filt_q)
        2'b01:   state_d = IN3;
        2'b10:   state_d = IN1;
        2'b00:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = IN2;
      endcase
      IN3: case (filt_q)
        2'b00:   begin state_d = IDLE; car_in_d = 1'b1; end
        2'b11:   state_d = IN2;
        2'b10:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = IN3;
      endcase
      OUT1: case (filt_q)
        2'b11:   state_d = OUT2;
        2'b00:   state_d = IDLE;
        2'b10:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = OUT1;
      endcase
      OUT2: case (filt_q)
        2'b10:   state_d = OUT3;
        2'b01:   state_d = OUT1;
        2'b00:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = OUT2;
      endcase
      OUT3: case (filt_q)
        2'b00:   begin state_d = IDLE; car_out_d = 1'b1; end
        2'b11:   state_d = OUT2;
        2'b01:   begin state_d = WAIT_CLR; err_d = 1'b1; end
        default: state_d = OUT3;
      endcase
      default: state_d = (filt_q == 2'b00) ? IDLE : WAIT_CLR;
    endcase

`ifdef CAR_FSM_TIMEOUT_EN
    // Every filtered change in a partial state moves the FSM, so "state held" equals "pair unchanged".
    to_cnt_d = 20'd0;
    if (state_q != IDLE && state_q != WAIT_CLR && state_d == state_q) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = WAIT_CLR;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 20'd1;
      end
    end
`endif

    cnt_en_d = car_in_d | car_out_d;
    cnt_up_d = ~car_out_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      filt_q    <= 2'b00;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_up_q  <= 1'b1;
`ifdef CAR_FSM_TIMEOUT_EN
      to_cnt_q  <= 20'd0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      car_in_q  <= car_in_d;
      car_out_q <= car_out_d;
      err_q     <= err_d;
      cnt_en_q  <= cnt_en_d;
      cnt_up_q  <= cnt_up_d;
`ifdef CAR_FSM_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign car_in    = car_in_q;
  assign car_out   = car_out_q;
  assign err       = err_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_up    = cnt_up_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_car_direction_fsm.sv
// Directed bench for car_direction_fsm (DB_CYCLES=2, TIMEOUT_CYCLES=50); the
// watchdog scenario expectations follow CAR_FSM_TIMEOUT_EN.
module tb_car_direction_fsm;

  localparam logic [2:0] S_IDLE = 3'd0, S_IN1 = 3'd1, S_IN2 = 3'd2, S_IN3 = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd7;
`ifdef CAR_FSM_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sens_a = 1'b0;
  logic       sens_b = 1'b0;
  logic       car_in, car_out, cnt_en, cnt_up, err, busy;
  logic [2:0] dbg_state;

  car_direction_fsm #(.DB_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .sens_a(sens_a), .sens_b(sens_b),
    .car_in(car_in), .car_out(car_out), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Event monitor: samples 1 ns after each rising edge.
  int   cyc = 0, n_in = 0, n_out = 0, n_err = 0, n_en = 0, n_busy = 0;
  int   bad_up = 0, both = 0, last_in_cyc = 0;
  logic out_up = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (car_in === 1'b1) begin n_in++; last_in_cyc = cyc; end
    if (car_out === 1'b1) begin n_out++; out_up = cnt_up; end
    if (err === 1'b1) n_err++;
    if (cnt_en === 1'b1) n_en++;
    if (busy === 1'b1) n_busy++;
    if (car_in === 1'b1 && car_out === 1'b1) both++;
    if (cnt_en !== (car_in | car_out)) bad_up++;
    if (cnt_en === 1'b0 && cnt_up !== 1'b1) bad_up++;
    if (cnt_en === 1'b1 && cnt_up !== car_in) bad_up++;
  end

  int n_tests = 0, n_fail = 0;
  int b_in, b_out, b_err, b_en, b_busy;
  int chg_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_in = n_in; b_out = n_out; b_err = n_err; b_en = n_en; b_busy = n_busy;
  endtask

  // Called on a falling edge; drives the pair and waits n falling edges.
  task automatic hold(input logic [1:0] p, input int n);
    sens_a = p[1];
    sens_b = p[0];
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rst_car_in", int'(car_in), 0);
    chk("rst_car_out", int'(car_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_cnt_up", int'(cnt_up), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(dbg_state), int'(S_IDLE));
    rst_n = 1'b1;
    hold(2'b00, 10);

    // Entry; the pulse lands on the 5th edge after the final pin change.
    snap();
    hold(2'b10, 10);
    chk("entry_busy", int'(busy), 1);
    hold(2'b11, 10);
    hold(2'b01, 10);
    chk("entry_state_in3", int'(dbg_state), int'(S_IN3));
    chg_cyc = cyc;
    hold(2'b00, 10);
    chk("entry_car_in", n_in - b_in, 1);
    chk("entry_cnt_en", n_en - b_en, 1);
    chk("entry_car_out", n_out - b_out, 0);
    chk("entry_err", n_err - b_err, 0);
    chk("entry_latency", last_in_cyc - chg_cyc, 5);
    chk("entry_busy_end", int'(busy), 0);

    // Exit
    snap();
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    hold(2'b00, 10);
    chk("exit_car_out", n_out - b_out, 1);
    chk("exit_cnt_up", int'(out_up), 0);
    chk("exit_car_in", n_in - b_in, 0);
    chk("exit_cnt_en", n_en - b_en, 1);
    chk("exit_err", n_err - b_err, 0);

    // Back-out
    snap();
    hold(2'b10, 10);
    hold(2'b11, 10);
    chk("back_state_in2", int'(dbg_state), int'(S_IN2));
    hold(2'b10, 10);
    chk("back_state_in1", int'(dbg_state), int'(S_IN1));
    hold(2'b00, 10);
    chk("back_pulses", (n_in - b_in) + (n_out - b_out), 0);
    chk("back_err", n_err - b_err, 0);
    chk("back_busy", int'(busy), 0);

    // Illegal 00 -> 11, then another non-00 pair, then clear
    snap();
    hold(2'b11, 10);
    chk("ill_err", n_err - b_err, 1);
    chk("ill_state", int'(dbg_state), int'(S_WAIT));
    chk("ill_busy", int'(busy), 1);
    hold(2'b01, 10);
    chk("ill_hold_state", int'(dbg_state), int'(S_WAIT));
    hold(2'b00, 10);
    chk("ill_busy_clr", int'(busy), 0);
    chk("ill_err_once", n_err - b_err, 1);
    chk("ill_pulses", (n_in - b_in) + (n_out - b_out), 0);

    // One-cycle glitch on sens_a in IDLE
    snap();
    hold(2'b10, 1);
    hold(2'b00, 12);
    chk("glitch_busy", n_busy - b_busy, 0);
    chk("glitch_state", int'(dbg_state), int'(S_IDLE));
    chk("glitch_outs", (n_in - b_in) + (n_out - b_out) + (n_err - b_err), 0);

    // Stall in IN1 for 60 cycles, then clear and a full entry
    snap();
    hold(2'b10, 60);
    chk("stall_err", n_err - b_err, TO_EN);
    chk("stall_state", int'(dbg_state), TO_EN ? int'(S_WAIT) : int'(S_IN1));
    hold(2'b00, 10);
    chk("stall_clear_state", int'(dbg_state), int'(S_IDLE));
    snap();
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b00, 10);
    chk("stall_entry_car_in", n_in - b_in, 1);
    chk("stall_entry_err", n_err - b_err, 0);

    // One-cycle reset while in IN2, sensors cleared together with reset
    hold(2'b10, 10);
    hold(2'b11, 10);
    chk("mrst_pre_state", int'(dbg_state), int'(S_IN2));
    snap();
    rst_n = 1'b0;
    hold(2'b00, 1);
    chk("mrst_state", int'(dbg_state), int'(S_IDLE));
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_cnt_up", int'(cnt_up), 1);
    chk("mrst_cnt_en", int'(cnt_en), 0);
    rst_n = 1'b1;
    hold(2'b00, 12);
    chk("mrst_pulses", (n_in - b_in) + (n_out - b_out) + (n_err - b_err), 0);
    chk("mrst_busy_after", n_busy - b_busy, 0);

    // Sensors blocked across reset release: 11 decodes as illegal from IDLE
    snap();
    rst_n = 1'b0;
    hold(2'b11, 2);
    rst_n = 1'b1;
    hold(2'b11, 10);
    chk("blk_rst_err", n_err - b_err, 1);
    chk("blk_rst_state", int'(dbg_state), int'(S_WAIT));
    hold(2'b00, 10);
    chk("blk_rst_clear", int'(dbg_state), int'(S_IDLE));

    chk("never_both", both, 0);
    chk("cnt_up_rule", bad_up, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
